wb_port_arbiter: RTL and testbench



---
 rtl/wb_port_arbiter.sv | 120 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter that merges pipeline writeback with late load returns.
// Losing loads wait in a small in-order FIFO, and a starvation timer forces a one-cycle freeze.
`ifndef REG_FILE_DEPTH
`define REG_FILE_DEPTH 5
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module wb_port_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pipe_WB_en,
  input  logic [`REG_FILE_DEPTH-1:0] pipe_dst,
  input  logic [`WORD_WIDTH-1:0]     pipe_value,
  input  logic                       ld_valid,
  input  logic [`REG_FILE_DEPTH-1:0] ld_dst,
  input  logic [`WORD_WIDTH-1:0]     ld_value,
  output logic                       ld_ready,
  output logic                       freeze,
  output logic                       pending,
  output logic                       WB_en_out,
  output logic [`REG_FILE_DEPTH-1:0] WB_Dest,
  output logic [`WORD_WIDTH-1:0]     WB_Value
);

  localparam int unsigned AW = `REG_FILE_DEPTH;
  localparam int unsigned DW = `WORD_WIDTH;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [AW-1:0] dst_mem [FIFO_DEPTH];
  logic [DW-1:0] val_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;

  logic          not_empty, full;
  logic          pop, push, bypass, wr;
  logic [AW-1:0] sel_dst;
  logic [DW-1:0] sel_val;

  assign not_empty = (count != '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign ld_ready  = !full;
  assign pending   = not_empty;

  // Strict priority: forced freeze pop, pipe, queued head, then empty-FIFO bypass.
  always_comb begin
    pop     = 1'b0;
    bypass  = 1'b0;
    wr      = 1'b0;
    sel_dst = '0;
    sel_val = '0;
    if (freeze && not_empty) begin
      pop     = 1'b1;
      wr      = 1'b1;
      sel_dst = dst_mem[rd_ptr];
      sel_val = val_mem[rd_ptr];
    end else if (pipe_WB_en) begin
      wr      = 1'b1;
      sel_dst = pipe_dst;
      sel_val = pipe_value;
    end else if (not_empty) begin
      pop     = 1'b1;
      wr      = 1'b1;
      sel_dst = dst_mem[rd_ptr];
      sel_val = val_mem[rd_ptr];
    end else if (ld_valid) begin
      bypass  = 1'b1;
      wr      = 1'b1;
      sel_dst = ld_dst;
      sel_val = ld_value;
    end
  end

  assign push = ld_valid && ld_ready && !bypass;

  always_ff @(posedge clk) begin
    if (push) begin
      dst_mem[wr_ptr] <= ld_dst;
      val_mem[wr_ptr] <= ld_value;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      freeze     <= 1'b0;
      WB_en_out  <= 1'b0;
      WB_Dest    <= '0;
      WB_Value   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);

      if (pop || !not_empty) starve_cnt <= '0;
      else                   starve_cnt <= starve_cnt + SW'(1);

      // A freeze cycle always pops, so this term self-clears the pulse.
      freeze <= (starve_cnt == SW'(STARVE_LIMIT - 1)) && not_empty && !pop;

      WB_en_out <= wr;
      if (wr) begin
        WB_Dest  <= sel_dst;
        WB_Value <= sel_val;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: pipe, bypass, collision, starvation, full FIFO, reset flush.
`ifndef REG_FILE_DEPTH
`define REG_FILE_DEPTH 5
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module tb_wb_port_arbiter;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       pipe_WB_en;
  logic [`REG_FILE_DEPTH-1:0] pipe_dst;
  logic [`WORD_WIDTH-1:0]     pipe_value;
  logic                       ld_valid;
  logic [`REG_FILE_DEPTH-1:0] ld_dst;
  logic [`WORD_WIDTH-1:0]     ld_value;
  logic                       ld_ready;
  logic                       freeze;
  logic                       pending;
  logic                       WB_en_out;
  logic [`REG_FILE_DEPTH-1:0] WB_Dest;
  logic [`WORD_WIDTH-1:0]     WB_Value;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  wb_port_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_WB_en(pipe_WB_en), .pipe_dst(pipe_dst), .pipe_value(pipe_value),
    .ld_valid(ld_valid), .ld_dst(ld_dst), .ld_value(ld_value),
    .ld_ready(ld_ready), .freeze(freeze), .pending(pending),
    .WB_en_out(WB_en_out), .WB_Dest(WB_Dest), .WB_Value(WB_Value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic pe, input logic [7:0] pd, input logic [31:0] pv,
                       input logic lv, input logic [7:0] ldd, input logic [31:0] lvv);
    pipe_WB_en = pe;
    pipe_dst   = pd[`REG_FILE_DEPTH-1:0];
    pipe_value = pv;
    ld_valid   = lv;
    ld_dst     = ldd[`REG_FILE_DEPTH-1:0];
    ld_value   = lvv;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic [7:0] d, input logic [31:0] v);
    check({tag, "_en"}, 64'(WB_en_out), 64'd1);
    check({tag, "_dst"}, 64'(WB_Dest), 64'(d));
    check({tag, "_val"}, 64'(WB_Value), 64'(v));
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    next_cycle();
    check("rst_en", 64'(WB_en_out), 0);
    check("rst_dst", 64'(WB_Dest), 0);
    check("rst_val", 64'(WB_Value), 0);
    check("rst_freeze", 64'(freeze), 0);
    check("rst_pending", 64'(pending), 0);
    check("rst_ready", 64'(ld_ready), 1);
    rst = 1'b0;

    // Pipe only
    drive(1, 3, 32'hDEADBEEF, 0, 0, 0);
    next_cycle();
    check_wr("pipe", 3, 32'hDEADBEEF);
    check("pipe_freeze", 64'(freeze), 0);
    check("pipe_pending", 64'(pending), 0);

    // Bypass
    drive(0, 0, 0, 1, 5, 32'h12345678);
    next_cycle();
    check_wr("bypass", 5, 32'h12345678);
    check("bypass_pending", 64'(pending), 0);

    // Collision
    drive(1, 2, 32'h11, 1, 7, 32'h22);
    next_cycle();
    check_wr("coll_c1", 2, 32'h11);
    check("coll_c1_pending", 64'(pending), 1);
    drive(0, 0, 0, 0, 0, 0);
    next_cycle();
    check_wr("coll_c2", 7, 32'h22);
    next_cycle();
    check("coll_c3_pending", 64'(pending), 0);
    check("coll_c3_en", 64'(WB_en_out), 0);
    check("coll_c3_hold", 64'(WB_Dest), 7);

    // Starvation: pipe held 10 cycles, upstream holds its value while frozen
    drive(1, 1, 32'h100, 1, 4, 32'hAA);
    for (int k = 1; k <= 10; k++) begin
      next_cycle();
      check($sformatf("starve_freeze_c%0d", k), 64'(freeze), 64'(k == 5));
      if (k == 6)
        check_wr("starve_load", 4, 32'hAA);
      else if (k <= 5)
        check_wr($sformatf("starve_pipe_c%0d", k), 1, 32'h100 + 32'(k - 1));
      else
        check_wr($sformatf("starve_pipe_c%0d", k), 1, 32'h100 + 32'(k - 2));
      if (k == 7) check("starve_cnt_c7", 64'(dut.starve_cnt), 0);
      if (k <= 9)
        drive(1, 1, 32'h100 + 32'((k <= 5) ? k : k - 1), 0, 0, 0);
      else
        drive(0, 0, 0, 0, 0, 0);
    end

    // Full FIFO
    drive(1, 1, 32'h200, 1, 8, 32'h808);
    next_cycle();
    check("full_f1_ready", 64'(ld_ready), 1);
    check("full_f1_pending", 64'(pending), 1);
    drive(1, 1, 32'h201, 1, 9, 32'h909);
    next_cycle();
    check("full_f2_ready", 64'(ld_ready), 0);
    drive(1, 1, 32'h202, 1, 10, 32'hA0A);
    next_cycle();
    check("full_f3_ready", 64'(ld_ready), 0);
    check_wr("full_f3_pipe", 1, 32'h202);
    drive(0, 0, 0, 1, 10, 32'hA0A);
    next_cycle();
    check_wr("full_ret8", 8, 32'h808);
    check("full_f4_ready", 64'(ld_ready), 1);
    drive(0, 0, 0, 1, 10, 32'hA0A);
    next_cycle();
    check_wr("full_ret9", 9, 32'h909);
    check("full_f5_pending", 64'(pending), 1);
    drive(0, 0, 0, 0, 0, 0);
    next_cycle();
    check_wr("full_ret10", 10, 32'hA0A);
    check("full_f6_pending", 64'(pending), 0);
    next_cycle();
    check("full_f7_en", 64'(WB_en_out), 0);

    // Reset mid-operation: two queued entries and freeze raised
    drive(1, 1, 32'h300, 1, 11, 32'hB0B);
    next_cycle();
    drive(1, 1, 32'h301, 1, 12, 32'hC0C);
    for (int k = 2; k <= 5; k++) begin
      next_cycle();
      drive(1, 1, 32'h300 + 32'(k), 0, 0, 0);
    end
    check("rmid_pre_freeze", 64'(freeze), 1);
    check("rmid_pre_full", 64'(ld_ready), 0);
    rst = 1'b1;
    #1;
    check("rmid_en", 64'(WB_en_out), 0);
    check("rmid_pending", 64'(pending), 0);
    check("rmid_ready", 64'(ld_ready), 1);
    check("rmid_freeze", 64'(freeze), 0);
    drive(0, 0, 0, 0, 0, 0);
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      check($sformatf("rpost_en_%0d", k), 64'(WB_en_out), 0);
      check($sformatf("rpost_pending_%0d", k), 64'(pending), 0);
      check($sformatf("rpost_freeze_%0d", k), 64'(freeze), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
